// File: rtl/segre_mem_arbiter.sv
// Arbitrates lane fills (and dirty-victim writebacks) from the data and instruction
// caches onto a single main-memory port, one request outstanding at a time.
module segre_mem_arbiter #(
    parameter int ADDR_SIZE = 32,
    parameter int LANE_SIZE = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dc_miss_i,
    input  logic                 dc_writeback_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    input  logic [ADDR_SIZE-1:0] dc_wb_addr_i,
    input  logic [LANE_SIZE-1:0] dc_wb_data_i,
    input  logic                 ic_miss_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 dc_data_rdy_o,
    output logic [LANE_SIZE-1:0] dc_data_o,
    output logic                 ic_data_rdy_o,
    output logic [LANE_SIZE-1:0] ic_data_o,
    output logic                 mm_rd_o,
    output logic                 mm_wr_o,
    output logic [ADDR_SIZE-1:0] mm_addr_o,
    output logic [LANE_SIZE-1:0] mm_wr_data_o,
    input  logic [LANE_SIZE-1:0] mm_rd_data_i,
    input  logic                 mm_data_rdy_i
);

    localparam logic [ADDR_SIZE-1:0] LANE_MASK = ~ADDR_SIZE'(4'hF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DC_WB   = 2'd1,
        DC_FILL = 2'd2,
        IC_FILL = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic                 last_dc_reg;
    logic                 dc_rdy_reg, ic_rdy_reg;
    logic [LANE_SIZE-1:0] dc_data_reg, ic_data_reg;
    logic [ADDR_SIZE-1:0] dc_addr_reg, dc_wb_addr_reg, ic_addr_reg;
    logic [LANE_SIZE-1:0] dc_wb_data_reg;

    logic dc_pending, ic_pending;
    logic grant_dc, grant_ic;
    logic dc_done, ic_done;

    // A requester whose rdy pulse is showing still holds its miss line; mask it.
    assign dc_pending = dc_miss_i & ~dc_rdy_reg;
    assign ic_pending = ic_miss_i & ~ic_rdy_reg;

    always_comb begin
        state_next = state_reg;
        grant_dc   = 1'b0;
        grant_ic   = 1'b0;
        dc_done    = 1'b0;
        ic_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dc_pending && (!ic_pending || !last_dc_reg)) begin
                    grant_dc   = 1'b1;
                    state_next = dc_writeback_i ? DC_WB : DC_FILL;
                end else if (ic_pending) begin
                    grant_ic   = 1'b1;
                    state_next = IC_FILL;
                end
            end
            DC_WB: begin
                if (mm_data_rdy_i) begin
                    state_next = DC_FILL;
                end
            end
            DC_FILL: begin
                if (mm_data_rdy_i) begin
                    dc_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            IC_FILL: begin
                if (mm_data_rdy_i) begin
                    ic_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            last_dc_reg    <= 1'b0;
            dc_rdy_reg     <= 1'b0;
            ic_rdy_reg     <= 1'b0;
            dc_data_reg    <= '0;
            ic_data_reg    <= '0;
            dc_addr_reg    <= '0;
            dc_wb_addr_reg <= '0;
            dc_wb_data_reg <= '0;
            ic_addr_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            dc_rdy_reg <= dc_done;
            ic_rdy_reg <= ic_done;
            // Addresses are captured already lane-aligned so the mm port decodes straight from registers.
            if (grant_dc) begin
                last_dc_reg    <= 1'b1;
                dc_addr_reg    <= dc_addr_i & LANE_MASK;
                dc_wb_addr_reg <= dc_wb_addr_i & LANE_MASK;
                dc_wb_data_reg <= dc_wb_data_i;
            end
            if (grant_ic) begin
                last_dc_reg <= 1'b0;
                ic_addr_reg <= ic_addr_i & LANE_MASK;
            end
            if (dc_done) begin
                dc_data_reg <= mm_rd_data_i;
            end
            if (ic_done) begin
                ic_data_reg <= mm_rd_data_i;
            end
        end
    end

    always_comb begin
        mm_rd_o      = 1'b0;
        mm_wr_o      = 1'b0;
        mm_addr_o    = '0;
        mm_wr_data_o = '0;
        case (state_reg)
            DC_WB: begin
                mm_wr_o      = 1'b1;
                mm_addr_o    = dc_wb_addr_reg;
                mm_wr_data_o = dc_wb_data_reg;
            end
            DC_FILL: begin
                mm_rd_o   = 1'b1;
                mm_addr_o = dc_addr_reg;
            end
            IC_FILL: begin
                mm_rd_o   = 1'b1;
                mm_addr_o = ic_addr_reg;
            end
            default: ;
        endcase
    end

    assign dc_data_rdy_o = dc_rdy_reg;
    assign ic_data_rdy_o = ic_rdy_reg;
    assign dc_data_o     = dc_data_reg;
    assign ic_data_o     = ic_data_reg;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: fills, writeback, alternation, masking and reset.
module tb_segre_mem_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         dc_miss_i, dc_writeback_i;
    logic [31:0]  dc_addr_i, dc_wb_addr_i;
    logic [127:0] dc_wb_data_i;
    logic         ic_miss_i;
    logic [31:0]  ic_addr_i;
    logic         dc_data_rdy_o, ic_data_rdy_o;
    logic [127:0] dc_data_o, ic_data_o;
    logic         mm_rd_o, mm_wr_o;
    logic [31:0]  mm_addr_o;
    logic [127:0] mm_wr_data_o;
    logic [127:0] mm_rd_data_i;
    logic         mm_data_rdy_i;

    int checks = 0;
    int failures = 0;

    segre_mem_arbiter #(.ADDR_SIZE(32), .LANE_SIZE(128)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dc_miss_i(dc_miss_i), .dc_writeback_i(dc_writeback_i),
        .dc_addr_i(dc_addr_i), .dc_wb_addr_i(dc_wb_addr_i), .dc_wb_data_i(dc_wb_data_i),
        .ic_miss_i(ic_miss_i), .ic_addr_i(ic_addr_i),
        .dc_data_rdy_o(dc_data_rdy_o), .dc_data_o(dc_data_o),
        .ic_data_rdy_o(ic_data_rdy_o), .ic_data_o(ic_data_o),
        .mm_rd_o(mm_rd_o), .mm_wr_o(mm_wr_o), .mm_addr_o(mm_addr_o),
        .mm_wr_data_o(mm_wr_data_o), .mm_rd_data_i(mm_rd_data_i),
        .mm_data_rdy_i(mm_data_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    logic [127:0] lane;
    logic [127:0] dc_exp, ic_exp;

    initial begin
        rst_i = 1'b1;
        dc_miss_i = 0; dc_writeback_i = 0; dc_addr_i = 0; dc_wb_addr_i = 0; dc_wb_data_i = 0;
        ic_miss_i = 0; ic_addr_i = 0; mm_rd_data_i = 0; mm_data_rdy_i = 0;
        step(); step();
        chk("rst_mm_rd", 128'(mm_rd_o), 128'd0);
        chk("rst_mm_wr", 128'(mm_wr_o), 128'd0);
        chk("rst_mm_addr", 128'(mm_addr_o), 128'd0);
        chk("rst_dc_rdy", 128'(dc_data_rdy_o), 128'd0);
        chk("rst_dc_data", dc_data_o, 128'd0);
        chk("rst_ic_data", ic_data_o, 128'd0);
        rst_i = 1'b0;

        // mm_data_rdy_i while idle is ignored
        mm_data_rdy_i = 1; mm_rd_data_i = {4{32'hDEADBEEF}};
        step();
        chk("idle_rdy_dc", 128'(dc_data_rdy_o), 128'd0);
        chk("idle_rdy_ic", 128'(ic_data_rdy_o), 128'd0);
        chk("idle_rdy_data", dc_data_o, 128'd0);
        mm_data_rdy_i = 0;

        // Plain dc fill, memory answers on the third fill cycle
        dc_miss_i = 1; dc_writeback_i = 0; dc_addr_i = 32'h0000_1234;
        step();
        chk("f1_rd", 128'(mm_rd_o), 128'd1);
        chk("f1_wr", 128'(mm_wr_o), 128'd0);
        chk("f1_addr", 128'(mm_addr_o), 128'h1230);
        step();
        step();
        chk("f1_rd_hold", 128'(mm_rd_o), 128'd1);
        chk("f1_no_early_rdy", 128'(dc_data_rdy_o), 128'd0);
        mm_data_rdy_i = 1; mm_rd_data_i = {16{8'hA5}};
        step();
        chk("f1_dc_rdy", 128'(dc_data_rdy_o), 128'd1);
        chk("f1_dc_data", dc_data_o, {16{8'hA5}});
        chk("f1_rd_off", 128'(mm_rd_o), 128'd0);
        dc_miss_i = 0; mm_data_rdy_i = 0; mm_rd_data_i = 0;
        step();
        chk("f1_rdy_pulse", 128'(dc_data_rdy_o), 128'd0);
        chk("f1_data_hold", dc_data_o, {16{8'hA5}});

        // Writeback then fill
        dc_miss_i = 1; dc_writeback_i = 1; dc_wb_addr_i = 32'h100; dc_addr_i = 32'h200;
        dc_wb_data_i = {4{32'h1111_2222}};
        step();
        chk("wb_wr", 128'(mm_wr_o), 128'd1);
        chk("wb_rd", 128'(mm_rd_o), 128'd0);
        chk("wb_addr", 128'(mm_addr_o), 128'h100);
        chk("wb_data", mm_wr_data_o, {4{32'h1111_2222}});
        dc_wb_addr_i = 32'h999; dc_wb_data_i = 0; dc_writeback_i = 0;
        step();
        chk("wb_addr_latched", 128'(mm_addr_o), 128'h100);
        chk("wb_data_latched", mm_wr_data_o, {4{32'h1111_2222}});
        mm_data_rdy_i = 1;
        step();
        chk("wbf_rd", 128'(mm_rd_o), 128'd1);
        chk("wbf_wr", 128'(mm_wr_o), 128'd0);
        chk("wbf_addr", 128'(mm_addr_o), 128'h200);
        chk("wbf_no_rdy", 128'(dc_data_rdy_o), 128'd0);
        mm_data_rdy_i = 0;
        step();
        mm_data_rdy_i = 1; mm_rd_data_i = {4{32'h3333_4444}};
        step();
        chk("wbf_dc_rdy", 128'(dc_data_rdy_o), 128'd1);
        chk("wbf_dc_data", dc_data_o, {4{32'h3333_4444}});
        dc_miss_i = 0; mm_data_rdy_i = 0;
        step();
        chk("wbf_single_rdy", 128'(dc_data_rdy_o), 128'd0);

        // Reset, then both request together: dc, ic, dc, ic
        rst_i = 1; step(); rst_i = 0;
        dc_miss_i = 1; dc_writeback_i = 0; dc_addr_i = 32'h300;
        ic_miss_i = 1; ic_addr_i = 32'h404;
        dc_exp = 0; ic_exp = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("alt%0d_rd", k), 128'(mm_rd_o), 128'd1);
            chk($sformatf("alt%0d_addr", k), 128'(mm_addr_o), (k % 2 == 0) ? 128'h300 : 128'h400);
            lane = {4{32'hC0DE_0000 + 32'(k)}};
            mm_data_rdy_i = 1; mm_rd_data_i = lane;
            if (k % 2 == 0) dc_exp = lane; else ic_exp = lane;
            step();
            chk($sformatf("alt%0d_dc_rdy", k), 128'(dc_data_rdy_o), (k % 2 == 0) ? 128'd1 : 128'd0);
            chk($sformatf("alt%0d_ic_rdy", k), 128'(ic_data_rdy_o), (k % 2 == 1) ? 128'd1 : 128'd0);
            chk($sformatf("alt%0d_dc_data", k), dc_data_o, dc_exp);
            chk($sformatf("alt%0d_ic_data", k), ic_data_o, ic_exp);
            mm_data_rdy_i = 0;
        end
        dc_miss_i = 0; ic_miss_i = 0;
        step();

        // Masking: dc held high through its rdy cycle gets no immediate regrant
        dc_miss_i = 1; dc_addr_i = 32'h0000_0A10;
        step();
        chk("mask_rd", 128'(mm_rd_o), 128'd1);
        mm_data_rdy_i = 1; mm_rd_data_i = {4{32'h5555_6666}};
        step();
        chk("mask_dc_rdy", 128'(dc_data_rdy_o), 128'd1);
        mm_data_rdy_i = 0;
        step();
        chk("mask_no_regrant", 128'(mm_rd_o), 128'd0);
        chk("mask_rdy_low", 128'(dc_data_rdy_o), 128'd0);
        dc_miss_i = 0;
        step();
        chk("mask_idle", 128'(mm_rd_o), 128'd0);

        // ic outstanding while its address changes and dc arrives
        ic_miss_i = 1; ic_addr_i = 32'h0000_5008;
        step();
        chk("ic_rd", 128'(mm_rd_o), 128'd1);
        chk("ic_addr", 128'(mm_addr_o), 128'h5000);
        ic_addr_i = 32'h7770; dc_miss_i = 1; dc_writeback_i = 0; dc_addr_i = 32'h600;
        step();
        chk("ic_addr_stable1", 128'(mm_addr_o), 128'h5000);
        step();
        chk("ic_addr_stable2", 128'(mm_addr_o), 128'h5000);
        mm_data_rdy_i = 1; mm_rd_data_i = {4{32'h7777_8888}};
        step();
        chk("ic_rdy", 128'(ic_data_rdy_o), 128'd1);
        chk("ic_data", ic_data_o, {4{32'h7777_8888}});
        chk("ic_dc_data_kept", dc_data_o, {4{32'h5555_6666}});
        ic_miss_i = 0; mm_data_rdy_i = 0;
        step();
        chk("dc_after_ic_rd", 128'(mm_rd_o), 128'd1);
        chk("dc_after_ic_addr", 128'(mm_addr_o), 128'h600);
        mm_data_rdy_i = 1; mm_rd_data_i = {4{32'h9999_AAAA}};
        step();
        chk("dc_after_ic_rdy", 128'(dc_data_rdy_o), 128'd1);
        dc_miss_i = 0; mm_data_rdy_i = 0;
        step();

        // Asynchronous reset mid-fill
        dc_miss_i = 1; dc_addr_i = 32'h800;
        step();
        chk("ar_rd_before", 128'(mm_rd_o), 128'd1);
        #2 rst_i = 1;
        #1;
        chk("ar_rd", 128'(mm_rd_o), 128'd0);
        chk("ar_addr", 128'(mm_addr_o), 128'd0);
        chk("ar_dc_data", dc_data_o, 128'd0);
        chk("ar_ic_data", ic_data_o, 128'd0);
        step();
        rst_i = 0; dc_miss_i = 0; mm_data_rdy_i = 1; mm_rd_data_i = {4{32'hBBBB_CCCC}};
        step();
        chk("ar_no_dc_rdy", 128'(dc_data_rdy_o), 128'd0);
        chk("ar_no_ic_rdy", 128'(ic_data_rdy_o), 128'd0);
        chk("ar_idle_rd", 128'(mm_rd_o), 128'd0);
        mm_data_rdy_i = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/segre_mem_arbiter.md
SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 32, byte-address width.
REQ-002 Parameter LANE_SIZE, default 128, cache-lane width in bits (16 bytes).
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset; asynchronous, active-high.
REQ-005 dc_miss_i  in  1  data-cache lane request; held high until dc_data_rdy_o.
REQ-006 dc_writeback_i  in  1  victim lane dirty; sampled with dc_miss_i at grant.
REQ-007 dc_addr_i  in  ADDR_SIZE  fill address.
REQ-008 dc_wb_addr_i  in  ADDR_SIZE  victim address.
REQ-009 dc_wb_data_i  in  LANE_SIZE  victim lane data.
REQ-010 ic_miss_i  in  1  instruction-cache lane request; held high until ic_data_rdy_o.
REQ-011 ic_addr_i  in  ADDR_SIZE  fill address.
REQ-012 dc_data_rdy_o / ic_data_rdy_o  out  1  one-cycle fill-complete pulse.
REQ-013 dc_data_o / ic_data_o  out  LANE_SIZE  registered fill lane, valid with the matching rdy pulse.
REQ-014 mm_rd_o / mm_wr_o  out  1  main-memory read / write request.
REQ-015 mm_addr_o  out  ADDR_SIZE  main-memory address, low 4 bits forced to 0.
REQ-016 mm_wr_data_o  out  LANE_SIZE  write lane.
REQ-017 mm_rd_data_i  in  LANE_SIZE  read lane, valid with mm_data_rdy_i.
REQ-018 mm_data_rdy_i  in  1  memory completion for the outstanding request.

Function
REQ-019 States: IDLE, DC_WB, DC_FILL, IC_FILL.
REQ-020 At most one memory request outstanding; mm_rd_o and mm_wr_o never both high.
REQ-021 IDLE, only dc pending: next state DC_WB if dc_writeback_i else DC_FILL.
REQ-022 IDLE, only ic pending: next state IC_FILL.
REQ-023 IDLE, both pending: grant the requester not served last; after reset, dc wins.
REQ-024 Requests are sampled only in IDLE; grant takes one cycle (request visible at IDLE edge, memory request asserted the following cycle).
REQ-025 DC_WB: mm_wr_o=1, mm_addr_o=dc_wb_addr_i aligned, mm_wr_data_o=dc_wb_data_i; on mm_data_rdy_i go to DC_FILL.
REQ-026 DC_FILL / IC_FILL: mm_rd_o=1, mm_addr_o=requester address aligned; on mm_data_rdy_i capture mm_rd_data_i into the matching data_o register and return to IDLE.
REQ-027 The matching rdy_o is high exactly the cycle after mm_data_rdy_i; data_o holds its value until the next fill for that port.
REQ-028 mm_addr_o, mm_wr_data_o, mm_rd_o and mm_wr_o hold stable while awaiting mm_data_rdy_i, regardless of requester input changes.
REQ-029 mm_data_rdy_i in IDLE is ignored.
REQ-030 The just-served requester is masked for arbitration during the cycle its rdy_o is high, preventing a duplicate grant.
REQ-031 Requester addresses are latched at grant; later changes do not affect the outstanding request.
REQ-032 mm_data_rdy_i in the same cycle as grant is not possible (request not yet issued) and is ignored.
REQ-033 Combinational output decode from the state and latched registers only; no input-to-output combinational path on the mm_* port.

Reset
REQ-034 rst_i high immediately forces IDLE; all outputs 0; data_o registers 0; last-served = ic (dc wins first tie).
REQ-035 Reset mid-transaction abandons it; no rdy pulse is produced for it after release.

Verification
REQ-036 dc_miss_i=1, dc_writeback_i=0, dc_addr_i=0x0000_1234, memory rdy after 3 cycles with 0xA5..A5 -> mm_rd_o high, mm_addr_o=0x0000_1230, dc_data_rdy_o one cycle later, dc_data_o=0xA5..A5.
REQ-037 dc_miss_i=1, dc_writeback_i=1, wb_addr=0x100, fill addr=0x200 -> mm_wr_o at 0x100 with wb data, then mm_rd_o at 0x200, single dc_data_rdy_o.
REQ-038 dc and ic asserted in the same cycle after reset -> dc served first, ic served next; repeat both asserted -> order alternates dc, ic, dc, ic.
REQ-039 ic fill outstanding, ic_addr_i changes and dc_miss_i rises -> mm_addr_o unchanged until mm_data_rdy_i; dc granted after ic_data_rdy_o.
REQ-040 rst_i asserted during DC_FILL -> outputs 0 asynchronously; mm_data_rdy_i after release produces no rdy pulse.
REQ-041 Requester keeps miss high through the rdy cycle -> no second grant that cycle (mask).
